// File: rtl/addr_arbiter_mux_if.sv
// Bus bundle between the address requesters (master side) and addr_arbiter_mux (slave side).
// The lock vector exists only when ADDR_ARB_LOCK_EN is defined.
interface addr_arbiter_mux_if #(
  parameter int WIDTH  = 5,
  parameter int NUM_CH = 2
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [NUM_CH-1:0]       req;
  logic [NUM_CH*WIDTH-1:0] addr_in;
`ifdef ADDR_ARB_LOCK_EN
  logic [NUM_CH-1:0]       lock;
`endif
  logic [NUM_CH-1:0]       gnt;
  logic [NUM_CH-1:0]       done;
  logic [WIDTH-1:0]        mem_addr;
  logic                    mem_en;
  logic                    busy;
  logic [CH_W-1:0]         cur_ch;

`ifdef ADDR_ARB_LOCK_EN
  modport master (
    output req, addr_in, lock,
    input  gnt, done, mem_addr, mem_en, busy, cur_ch
  );

  modport slave (
    input  req, addr_in, lock,
    output gnt, done, mem_addr, mem_en, busy, cur_ch
  );
`else
  modport master (
    output req, addr_in,
    input  gnt, done, mem_addr, mem_en, busy, cur_ch
  );

  modport slave (
    input  req, addr_in,
    output gnt, done, mem_addr, mem_en, busy, cur_ch
  );
`endif
endinterface

// File: rtl/addr_arbiter_mux.sv
// Registered NUM_CH-way address arbiter/mux in front of the CPU memory port (round-robin or fixed priority).
// Define ADDR_ARB_LOCK_EN to let the channel just served keep the port while it holds lock.
module addr_arbiter_mux #(
  parameter int WIDTH   = 5,
  parameter int NUM_CH  = 2,
  parameter int MEM_LAT = 1,
  parameter int RR      = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  addr_arbiter_mux_if.slave bus
);
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t            state_reg, state_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic [CH_W-1:0]   ptr_reg, ptr_next;
  logic [NUM_CH-1:0] gnt_reg, gnt_next;
  logic [NUM_CH-1:0] done_reg, done_next;
  logic [WIDTH-1:0]  mem_addr_reg, mem_addr_next;
  logic              mem_en_reg, mem_en_next;
  logic              busy_reg, busy_next;
  logic [CH_W-1:0]   cur_ch_reg, cur_ch_next;

  logic [WIDTH-1:0]  ch_addr [NUM_CH];
  logic [CH_W-1:0]   arb_ch;
  logic [CH_W-1:0]   issue_ch;
  logic              lock_hit;

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_addr
    assign ch_addr[gi] = bus.addr_in[gi*WIDTH +: WIDTH];
  end

  // Winner among the requesting channels; only meaningful when |req.
  always_comb begin
    logic          found;
    logic [CH_W-1:0] cand;
    arb_ch = '0;
    found  = 1'b0;
    cand   = '0;
    if (RR != 0) begin
      for (int k = 1; k <= NUM_CH; k++) begin
        cand = CH_W'((int'(ptr_reg) + k) % NUM_CH);
        if (!found && bus.req[cand]) begin
          found  = 1'b1;
          arb_ch = cand;
        end
      end
    end else begin
      for (int i = NUM_CH - 1; i >= 0; i--) begin
        cand = CH_W'(i);
        if (bus.req[cand]) begin
          arb_ch = cand;
        end
      end
    end
  end

`ifdef ADDR_ARB_LOCK_EN
  assign lock_hit = (state_reg == DONE) && bus.lock[cur_ch_reg] && bus.req[cur_ch_reg];
`else
  assign lock_hit = 1'b0;
`endif

  assign issue_ch = lock_hit ? cur_ch_reg : arb_ch;

  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    ptr_next      = ptr_reg;
    gnt_next      = '0;
    done_next     = '0;
    mem_en_next   = 1'b0;
    busy_next     = busy_reg;
    mem_addr_next = mem_addr_reg;
    cur_ch_next   = cur_ch_reg;

    case (state_reg)
      ACCESS: begin
        if (cnt_reg == '0) begin
          state_next = DONE;
          done_next  = NUM_CH'(1) << cur_ch_reg;
          busy_next  = 1'b0;
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end

      default: begin
        // IDLE and DONE both sample req, giving MEM_LAT+1 spacing when req is held.
        if (|bus.req) begin
          state_next    = ACCESS;
          cnt_next      = CNT_W'(MEM_LAT - 1);
          gnt_next      = NUM_CH'(1) << issue_ch;
          mem_en_next   = 1'b1;
          busy_next     = 1'b1;
          mem_addr_next = ch_addr[issue_ch];
          cur_ch_next   = issue_ch;
          if (!lock_hit && (RR != 0)) begin
            ptr_next = issue_ch;
          end
        end else begin
          state_next = IDLE;
          busy_next  = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      ptr_reg      <= CH_W'(NUM_CH - 1);
      gnt_reg      <= '0;
      done_reg     <= '0;
      mem_addr_reg <= '0;
      mem_en_reg   <= 1'b0;
      busy_reg     <= 1'b0;
      cur_ch_reg   <= '0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      ptr_reg      <= ptr_next;
      gnt_reg      <= gnt_next;
      done_reg     <= done_next;
      mem_addr_reg <= mem_addr_next;
      mem_en_reg   <= mem_en_next;
      busy_reg     <= busy_next;
      cur_ch_reg   <= cur_ch_next;
    end
  end

  assign bus.gnt      = gnt_reg;
  assign bus.done     = done_reg;
  assign bus.mem_addr = mem_addr_reg;
  assign bus.mem_en   = mem_en_reg;
  assign bus.busy     = busy_reg;
  assign bus.cur_ch   = cur_ch_reg;

  a_gnt_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(gnt_reg));
  a_done_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(done_reg));
  a_en_matches_gnt: assert property (@(posedge clk) disable iff (!rst_n) mem_en_reg == (|gnt_reg));
  a_gnt_single: assert property (@(posedge clk) disable iff (!rst_n) (|gnt_reg) |=> (gnt_reg == '0));
  a_done_single: assert property (@(posedge clk) disable iff (!rst_n) (|done_reg) |=> (done_reg == '0));

endmodule
